// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_param
// Brief    : WIDTH-bit up/down counter with load, wrap/saturate, Gray output
//            and registered terminal-count / direction-reversal pulses.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0,
    parameter int MAX_VAL  = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             gray_sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             y_out,
    output logic             dir_chg
);

    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam bit               c_SAT  = (SATURATE != 0);

    logic [WIDTH-1:0] r_cnt;
    logic             r_last_dir;
    logic             r_y_out;
    logic             r_dir_chg;

    logic             w_at_top;
    logic             w_at_bot;
    logic             w_terminal;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_top   = (r_cnt == c_MAX);
    assign w_at_bot   = (r_cnt == c_ZERO);
    assign w_terminal = x ? w_at_top : w_at_bot;

    // The wrap point is MAX_VAL, not the natural 2**WIDTH-1 rollover.
    always_comb begin
        w_step_val = r_cnt;
        if (x) begin
            if (w_at_top) w_step_val = c_SAT ? c_MAX : c_ZERO;
            else          w_step_val = r_cnt + c_ONE;
        end else begin
            if (w_at_bot) w_step_val = c_SAT ? c_ZERO : c_MAX;
            else          w_step_val = r_cnt - c_ONE;
        end
    end

    assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= c_ZERO;
            r_last_dir <= 1'b1;
            r_y_out    <= 1'b0;
            r_dir_chg  <= 1'b0;
        end else if (load) begin
            r_cnt      <= w_load_clamped;
            r_y_out    <= 1'b0;
            r_dir_chg  <= 1'b0;
        end else if (en) begin
            r_cnt      <= w_step_val;
            r_y_out    <= w_terminal;
            r_dir_chg  <= (x != r_last_dir);
            r_last_dir <= x;
        end else begin
            r_y_out    <= 1'b0;
            r_dir_chg  <= 1'b0;
        end
    end

    assign count   = gray_sel ? (r_cnt ^ (r_cnt >> 1)) : r_cnt;
    assign y_out   = r_y_out;
    assign dir_chg = r_dir_chg;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_counter_param
// Brief    : Bench for updown_counter_param: default wrap build, saturating
//            MAX_VAL=10 build and wrapping MAX_VAL=10 build share one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    localparam int c_N = 3;

    logic       clk;
    logic       reset;
    logic       en;
    logic       x;
    logic       gray_sel;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_o [c_N];
    logic [2:0] y_o;
    logic [2:0] dc_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: plain integers per instance.
    int mcnt  [c_N];
    int mlast [c_N];
    int my    [c_N];
    int mdc   [c_N];
    int maxv  [c_N] = '{15, 10, 10};
    int satv  [c_N] = '{0, 1, 0};

    updown_counter_param #(.WIDTH(4)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .x(x), .gray_sel(gray_sel),
        .load(load), .load_val(load_val), .count(cnt_o[0]),
        .y_out(y_o[0]), .dir_chg(dc_o[0])
    );

    updown_counter_param #(.WIDTH(4), .SATURATE(1), .MAX_VAL(10)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .x(x), .gray_sel(gray_sel),
        .load(load), .load_val(load_val), .count(cnt_o[1]),
        .y_out(y_o[1]), .dir_chg(dc_o[1])
    );

    updown_counter_param #(.WIDTH(4), .SATURATE(0), .MAX_VAL(10)) dut_w10 (
        .clk(clk), .reset(reset), .en(en), .x(x), .gray_sel(gray_sel),
        .load(load), .load_val(load_val), .count(cnt_o[2]),
        .y_out(y_o[2]), .dir_chg(dc_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] enc(input int c, input logic g);
        logic [3:0] b;
        b = c[3:0];
        return g ? (b ^ (b >> 1)) : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_N; i++) begin
            mcnt[i] = 0; mlast[i] = 1; my[i] = 0; mdc[i] = 0;
        end
    endtask

    task automatic model_step(input bit l, input bit e, input bit xx, input int lv);
        for (int i = 0; i < c_N; i++) begin
            int m;
            m = maxv[i];
            if (l) begin
                mcnt[i] = (lv > m) ? m : lv;
                my[i] = 0; mdc[i] = 0;
            end else if (e) begin
                mdc[i]   = (int'(xx) != mlast[i]) ? 1 : 0;
                mlast[i] = int'(xx);
                my[i]    = ((xx && mcnt[i] == m) || (!xx && mcnt[i] == 0)) ? 1 : 0;
                if (satv[i] != 0)
                    mcnt[i] = xx ? ((mcnt[i] + 1 > m) ? m : mcnt[i] + 1)
                                 : ((mcnt[i] - 1 < 0) ? 0 : mcnt[i] - 1);
                else
                    mcnt[i] = xx ? ((mcnt[i] + 1) % (m + 1))
                                 : ((mcnt[i] + m) % (m + 1));
            end else begin
                my[i] = 0; mdc[i] = 0;
            end
        end
    endtask

    task automatic cmp(input string tag, input int inst, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s inst%0d %s: observed=%0h expected=%0h", tag, inst, what, obs, exp);
    endtask

    task automatic check(input string tag);
        for (int i = 0; i < c_N; i++) begin
            cmp(tag, i, "count",   32'(cnt_o[i]), 32'(enc(mcnt[i], gray_sel)));
            cmp(tag, i, "y_out",   32'(y_o[i]),   32'(my[i]));
            cmp(tag, i, "dir_chg", 32'(dc_o[i]),  32'(mdc[i]));
        end
    endtask

    task automatic cycle(input bit l, input bit e, input bit xx, input logic [3:0] lv,
                         input string tag);
        load = l; en = e; x = xx; load_val = lv;
        @(posedge clk);
        model_step(l, e, xx, int'(lv));
        #1;
        check(tag);
    endtask

    initial begin
        logic [3:0] prev;
        reset = 1'b0; en = 1'b0; x = 1'b1; gray_sel = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #2;
        check("reset_init");
        #10 reset = 1'b1;

        // Up-count wrap from 0 for 17 edges.
        for (int k = 0; k < 17; k++) cycle(0, 1, 1, 4'd0, "up_wrap");

        // Async reset mid-cycle while the count sits at 9.
        cycle(1, 0, 1, 4'd9, "load9");
        #3 reset = 1'b0;
        model_reset();
        #1 check("async_reset");
        en = 1'b1;
        @(posedge clk);
        #1 check("reset_hold");
        #2 reset = 1'b1;

        // Down from 5 then reversal.
        cycle(1, 0, 0, 4'd5, "load5");
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 4'd0, "down");
        cycle(0, 1, 1, 4'd0, "reverse");
        cycle(0, 1, 1, 4'd0, "after_rev");

        // Gray sequence 0..7 with single-bit steps.
        gray_sel = 1'b1;
        cycle(1, 0, 1, 4'd0, "gray_load0");
        prev = cnt_o[0];
        for (int k = 0; k < 7; k++) begin
            cycle(0, 1, 1, 4'd0, "gray_up");
            cmp("gray_onebit", 0, "bits_changed", 32'($countones(prev ^ cnt_o[0])), 32'd1);
            prev = cnt_o[0];
        end
        gray_sel = 1'b0;
        #1 check("gray_off");

        // Clamped load then pinning at both ends.
        cycle(1, 1, 1, 4'd14, "load14");
        for (int k = 0; k < 3; k++)  cycle(0, 1, 1, 4'd0, "sat_top");
        for (int k = 0; k < 11; k++) cycle(0, 1, 0, 4'd0, "sat_down");
        cycle(0, 1, 0, 4'd0, "sat_bottom");

        // Load priority over enable.
        cycle(1, 0, 1, 4'd3, "load3");
        cycle(1, 1, 1, 4'd7, "load_prio");
        cycle(0, 0, 1, 4'd0, "hold7");
        cycle(0, 0, 0, 4'd0, "hold7_dirflip");
        cycle(0, 1, 0, 4'd0, "flag_on_enable");

        // Randomized phase.
        for (int k = 0; k < 400; k++) begin
            bit       rl, re, rx;
            logic [3:0] rv;
            rl = ($urandom_range(0, 9) == 0);
            re = ($urandom_range(0, 3) != 0);
            rx = ($urandom_range(0, 2) != 0) ^ k[5];
            rv = 4'($urandom_range(0, 15));
            gray_sel = 1'($urandom_range(0, 1));
            cycle(rl, re, rx, rv, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
